// File: rtl/fpgc_cpu_pkg.sv
// Shared CPU definitions for the fetch stage.
// Contents: bus/data widths, the word substituted on a bus timeout, the fetch FSM
// state encoding, and a helper that sizes the timeout counter.
package fpgc_cpu_pkg;

  localparam int unsigned ADDR_W = 27;
  localparam int unsigned DATA_W = 32;

  localparam logic [DATA_W-1:0] FETCH_NOP_WORD = '0;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } fetch_state_e;

  // Counter must hold TIMEOUT_CYC; keep at least one bit when the timeout is disabled.
  function automatic int unsigned fetch_cnt_w(input int unsigned timeout_cyc);
    return (timeout_cyc == 0) ? 1 : $clog2(timeout_cyc + 1);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage signal bundle: PC/request side from the program counter, read
// handshake to the memory unit, and the instruction delivered to decode.
// Modports:
//   master - the fetch unit (drives the bus request and the decode outputs)
//   slave  - its environment (PC source, memory unit, decode)
interface instr_fetch_if;
  import fpgc_cpu_pkg::*;

  logic [ADDR_W-1:0] pc;
  logic              fetch_req;
  logic              flush;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_start;
  logic [DATA_W-1:0] bus_data;
  logic              bus_done;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              fetch_busy;
  logic              fetch_err;

  modport master (
    input  pc, fetch_req, flush, bus_data, bus_done,
    output bus_addr, bus_start, instr, instr_valid, fetch_busy, fetch_err
  );

  modport slave (
    output pc, fetch_req, flush, bus_data, bus_done,
    input  bus_addr, bus_start, instr, instr_valid, fetch_busy, fetch_err
  );

endinterface

// File: rtl/fetch_line_cache.sv
// Single-entry last-word instruction cache (tag, data, valid bit).
// Ports:
//   clk, reset_n    clock, synchronous active-low reset (invalidates the entry)
//   i_lookup_addr   address being fetched; o_hit/o_hit_data answer combinationally
//   i_flush         invalidate the entry; also suppresses a hit in the same cycle
//   i_fill          write i_fill_addr/i_fill_data and mark valid (flush has priority)
module fetch_line_cache
  import fpgc_cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] i_lookup_addr,
  input  logic              i_flush,
  input  logic              i_fill,
  input  logic [ADDR_W-1:0] i_fill_addr,
  input  logic [DATA_W-1:0] i_fill_data,
  output logic              o_hit,
  output logic [DATA_W-1:0] o_hit_data
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_tag;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_fill) begin
      r_valid <= 1'b1;
      r_tag   <= i_fill_addr;
      r_data  <= i_fill_data;
    end
  end

  // A flush in the lookup cycle is treated as happening first.
  assign o_hit      = r_valid && (r_tag == i_lookup_addr) && !i_flush;
  assign o_hit_data = r_data;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: reads the word at the sampled PC over the memory-unit
// handshake and presents it to decode with a one-cycle valid strobe. A wait longer
// than TIMEOUT_CYC cycles (0 disables) delivers NOP_WORD and sets a sticky error.
// Ports:
//   clk, reset_n  clock, synchronous active-low reset
//   bus           instr_fetch_if.master: pc/fetch_req/flush in, bus_addr/bus_start
//                 out, bus_data/bus_done in, instr/instr_valid/fetch_busy/fetch_err out
// Build option: define FETCH_CACHE_EN to add a single-entry last-word cache; without
// it every fetch uses the bus and flush is ignored.
module instr_fetch
  import fpgc_cpu_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYC = 255,
  parameter logic [DATA_W-1:0] NOP_WORD    = FETCH_NOP_WORD
) (
  input logic           clk,
  input logic           reset_n,
  instr_fetch_if.master bus
);

  localparam int unsigned     CntW    = fetch_cnt_w(TIMEOUT_CYC);
  localparam logic [CntW-1:0] CntTerm = CntW'(TIMEOUT_CYC - 1);
  localparam logic [CntW-1:0] CntMax  = '1;

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_bus_addr;
  logic              r_bus_start;
  logic [DATA_W-1:0] r_instr;
  logic              r_instr_valid;
  logic              r_fetch_err;
  logic [CntW-1:0]   r_cnt;

  logic              w_hit;
  logic [DATA_W-1:0] w_hit_data;
  logic              w_timeout;

  // Counter holds the number of completed WAIT cycles, so the TIMEOUT_CYC-th WAIT
  // cycle is the terminal one; bus_done in that cycle still takes priority.
  assign w_timeout = (TIMEOUT_CYC != 0) && (r_cnt == CntTerm);

`ifdef FETCH_CACHE_EN
  logic w_fill;
  logic r_no_fill;

  // A flush while the read is outstanding means the returning word may be stale.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_no_fill <= 1'b0;
    end else if (r_state == StIdle && bus.fetch_req) begin
      r_no_fill <= 1'b0;
    end else if (bus.flush) begin
      r_no_fill <= 1'b1;
    end
  end

  assign w_fill = (r_state == StWait) && bus.bus_done && !r_no_fill && !bus.flush;

  fetch_line_cache u_cache (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_lookup_addr(bus.pc),
    .i_flush      (bus.flush),
    .i_fill       (w_fill),
    .i_fill_addr  (r_bus_addr),
    .i_fill_data  (bus.bus_data),
    .o_hit        (w_hit),
    .o_hit_data   (w_hit_data)
  );
`else
  logic w_unused_flush;

  assign w_hit          = 1'b0;
  assign w_hit_data     = '0;
  assign w_unused_flush = bus.flush;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= StIdle;
      r_bus_addr    <= '0;
      r_bus_start   <= 1'b0;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_bus_start   <= 1'b0;
      r_instr_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (bus.fetch_req) begin
            r_fetch_err <= 1'b0;
            if (w_hit) begin
              r_instr       <= w_hit_data;
              r_instr_valid <= 1'b1;
              r_state       <= StDone;
            end else begin
              r_bus_addr  <= bus.pc;
              r_bus_start <= 1'b1;
              r_state     <= StReq;
            end
          end
        end
        StReq: begin
          r_cnt   <= '0;
          r_state <= StWait;
        end
        StWait: begin
          if (r_cnt != CntMax) begin
            r_cnt <= r_cnt + 1'b1;
          end
          if (bus.bus_done) begin
            r_instr       <= bus.bus_data;
            r_instr_valid <= 1'b1;
            r_state       <= StDone;
          end else if (w_timeout) begin
            r_instr       <= NOP_WORD;
            r_fetch_err   <= 1'b1;
            r_instr_valid <= 1'b1;
            r_state       <= StDone;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.bus_addr    = r_bus_addr;
  assign bus.bus_start   = r_bus_start;
  assign bus.instr       = r_instr;
  assign bus.instr_valid = r_instr_valid;
  assign bus.fetch_busy  = (r_state != StIdle);
  assign bus.fetch_err   = r_fetch_err;

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed table, reset/stray-completion sequence and
// randomized fetches checked against a transaction-level model of the fetch stage.
module tb_instr_fetch;
  import fpgc_cpu_pkg::*;

  localparam int unsigned TO = 4;
`ifdef FETCH_CACHE_EN
  localparam bit CacheEn = 1'b1;
`else
  localparam bit CacheEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  instr_fetch_if bus ();

  instr_fetch #(
    .TIMEOUT_CYC(TO),
    .NOP_WORD   (32'h0)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the last-word cache contents.
  bit          m_valid = 1'b0;
  logic [26:0] m_tag   = '0;
  logic [31:0] m_data  = '0;

  typedef struct {
    string       name;
    logic [26:0] pc;
    int          lat;     // cycles from bus_start to bus_done; 0 = never
    logic [31:0] data;
    int          req2_c;  // cycle of an extra fetch_req (pc=0x20), -1 none
    int          flush_c; // cycle of a flush pulse, -1 none
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_state(input string name);
    check({name, " bus_addr"}, 64'(bus.bus_addr), 64'h0);
    check({name, " bus_start"}, 64'(bus.bus_start), 64'h0);
    check({name, " instr"}, 64'(bus.instr), 64'h0);
    check({name, " instr_valid"}, 64'(bus.instr_valid), 64'h0);
    check({name, " fetch_busy"}, 64'(bus.fetch_busy), 64'h0);
    check({name, " fetch_err"}, 64'(bus.fetch_err), 64'h0);
  endtask

  // One fetch issued in cycle 0. Expectations come from the transaction rules:
  // hit -> valid at 1, no bus; bus reply within TO -> valid at 2+lat; else NOP at 2+TO.
  task automatic run_fetch(input string name, input logic [26:0] pc, input int lat,
                           input logic [31:0] data, input int req2_in, input int flush_c,
                           output logic [31:0] got_instr, output logic got_err);
    bit          hit, to;
    logic [31:0] exp_instr;
    int          exp_vc, stop, req2_c;
    int          starts = 0, vcnt = 0, vc = -1, start_c = -1;
    logic [26:0] addr = '0;
    logic        busy1 = 1'b0, err1 = 1'b1;

    got_instr = '0;
    got_err   = 1'b0;
    if (CacheEn && flush_c == 0) m_valid = 1'b0;
    hit       = CacheEn && m_valid && (m_tag == pc);
    to        = !hit && (lat == 0 || lat > int'(TO));
    exp_instr = hit ? m_data : (to ? 32'h0 : data);
    exp_vc    = hit ? 1 : (to ? 2 + int'(TO) : 2 + lat);
    req2_c    = hit ? -1 : req2_in;
    if (CacheEn) begin
      if (!hit && !to && flush_c != 2) begin
        m_valid = 1'b1;
        m_tag   = pc;
        m_data  = data;
      end
      if (flush_c == 2) m_valid = 1'b0;
    end
    stop = ((lat > 0 && 1 + lat > exp_vc) ? 1 + lat : exp_vc) + 2;

    bus.pc        = pc;
    bus.fetch_req = 1'b1;
    bus.flush     = (flush_c == 0);
    bus.bus_done  = 1'b0;
    for (int c = 0; c <= stop; c++) begin
      if (bus.bus_start) begin
        starts++;
        addr = bus.bus_addr;
        if (start_c < 0) start_c = c;
      end
      if (bus.instr_valid) begin
        vcnt++;
        if (vc < 0) begin
          vc        = c;
          got_instr = bus.instr;
          got_err   = bus.fetch_err;
        end
      end
      if (c == 1) begin
        busy1 = bus.fetch_busy;
        err1  = bus.fetch_err;
      end
      @(posedge clk);
      #1;
      bus.fetch_req = (c + 1 == req2_c);
      bus.pc        = (c + 1 == req2_c) ? 27'h20 : 27'($urandom);
      bus.flush     = (c + 1 == flush_c);
      bus.bus_done  = (start_c >= 0) && (lat > 0) && (c + 1 == start_c + lat);
      bus.bus_data  = bus.bus_done ? data : $urandom;
    end
    bus.fetch_req = 1'b0;
    bus.flush     = 1'b0;
    bus.bus_done  = 1'b0;

    check({name, " bus_start count"}, 64'(starts), hit ? 64'd0 : 64'd1);
    if (!hit) check({name, " bus_addr"}, 64'(addr), 64'(pc));
    check({name, " valid cycle"}, 64'(vc), 64'(exp_vc));
    check({name, " valid pulses"}, 64'(vcnt), 64'd1);
    check({name, " instr"}, 64'(got_instr), 64'(exp_instr));
    check({name, " fetch_err"}, 64'(got_err), 64'(to));
    check({name, " busy in flight"}, 64'(busy1), 64'd1);
    check({name, " err cleared"}, 64'(err1), 64'd0);
    check({name, " idle after"}, 64'(bus.fetch_busy), 64'd0);
  endtask

  vec_t        vecs[11];
  logic [31:0] gi;
  logic        ge;

  initial begin
    vecs[0]  = '{"basic", 27'h10, 3, 32'hDEADBEEF, -1, -1, 32'hDEADBEEF, 1'b0};
    vecs[1]  = '{"busy", 27'h30, 4, 32'h11112222, 3, -1, 32'h11112222, 1'b0};
    vecs[2]  = '{"timeout", 27'h50, 0, 32'h33333333, -1, -1, 32'h0, 1'b1};
    vecs[3]  = '{"after_to", 27'h60, 1, 32'h44444444, -1, -1, 32'h44444444, 1'b0};
    vecs[4]  = '{"terminal", 27'h70, 4, 32'h55555555, -1, -1, 32'h55555555, 1'b0};
    vecs[5]  = '{"late", 27'h80, 5, 32'h66666666, -1, -1, 32'h0, 1'b1};
    vecs[6]  = '{"fill40", 27'h40, 2, 32'h77777777, -1, -1, 32'h77777777, 1'b0};
    vecs[7]  = '{"again40", 27'h40, 2, 32'h77777777, -1, -1, 32'h77777777, 1'b0};
    vecs[8]  = '{"flush40", 27'h40, 2, 32'h88888888, -1, 0, 32'h88888888, 1'b0};
    vecs[9]  = '{"flushwait", 27'h90, 3, 32'h99999999, -1, 2, 32'h99999999, 1'b0};
    vecs[10] = '{"again90", 27'h90, 1, 32'hAAAAAAAA, -1, -1, 32'hAAAAAAAA, 1'b0};

    reset_n       = 1'b0;
    bus.pc        = '0;
    bus.fetch_req = 1'b0;
    bus.flush     = 1'b0;
    bus.bus_data  = '0;
    bus.bus_done  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      run_fetch(vecs[i].name, vecs[i].pc, vecs[i].lat, vecs[i].data, vecs[i].req2_c,
                vecs[i].flush_c, gi, ge);
      check({vecs[i].name, " table instr"}, 64'(gi), 64'(vecs[i].exp_instr));
      check({vecs[i].name, " table err"}, 64'(ge), 64'(vecs[i].exp_err));
    end

    // Reset in the middle of WAIT, then a stray completion.
    bus.pc        = 27'h123;
    bus.fetch_req = 1'b1;
    @(posedge clk);
    #1;
    bus.fetch_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midwait busy", 64'(bus.fetch_busy), 64'd1);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n      = 1'b1;
    m_valid      = 1'b0;
    bus.bus_done = 1'b1;
    bus.bus_data = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    bus.bus_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("stray valid", 64'(bus.instr_valid), 64'd0);
      @(posedge clk);
      #1;
    end
    check_reset_state("midreset");

    // Randomized fetches against the model.
    for (int n = 0; n < 40; n++) begin
      logic [26:0] rpc;
      int          sel, rflush, rreq2;
      sel    = $urandom_range(0, 3);
      rpc    = (sel == 0) ? 27'h40 : (sel == 1) ? 27'h41 : (sel == 2) ? 27'h90 : 27'($urandom);
      sel    = $urandom_range(0, 5);
      rflush = (sel == 0) ? 0 : (sel == 1) ? 2 : -1;
      sel    = $urandom_range(0, 3);
      rreq2  = (sel == 0) ? 2 : (sel == 1) ? 3 : -1;
      run_fetch($sformatf("rand%0d", n), rpc, int'($urandom_range(0, 6)), $urandom, rreq2,
                rflush, gi, ge);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
